motor_cmd_queue: RTL and testbench



---
 rtl/motor_cmd_queue_if.sv | 23 ++
 rtl/motor_cmd_queue.sv | 112 +++++++++++
 tb/tb_motor_cmd_queue.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/motor_cmd_queue_if.sv
// motor_cmd_queue_if: command, motor-feedback and move-output bundle for motor_cmd_queue
interface motor_cmd_queue_if #(parameter int DEPTH = 4);
  logic cmd_valid;
  logic cmd_ready;
  logic [18:0] cmd_pos;
  logic [12:0] cmd_div;
  logic flush;
  logic [18:0] cur_position;
  logic motor_active;
  logic step_in;
  logic [18:0] newPos;
  logic [12:0] divider;
  logic busy;
  logic [$clog2(DEPTH):0] level;
  modport master (
    output cmd_valid, cmd_pos, cmd_div, flush, cur_position, motor_active, step_in,
    input  cmd_ready, newPos, divider, busy, level
  );
  modport slave (
    input  cmd_valid, cmd_pos, cmd_div, flush, cur_position, motor_active, step_in,
    output cmd_ready, newPos, divider, busy, level
  );
endinterface

// File: rtl/motor_cmd_queue.sv
// motor_cmd_queue: FIFO of moves issued one at a time to the step controller; trapezoidal ramp under MOTOR_CMD_QUEUE_RAMP_EN
module motor_cmd_queue #(
  parameter int DEPTH = 4,
  parameter logic [12:0] START_DIV = 13'd4000,
  parameter logic [12:0] RAMP_STEP = 13'd16
) (
  input logic CLK,
  input logic reset,
  motor_cmd_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state, state_nx;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [18:0] new_pos, head_pos;
  logic [12:0] divider, head_div, load_div;
  logic full, push, pop, done;
  assign full = level == LW'(DEPTH);
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign pop = state == LOAD;
  assign done = bus.cur_position == new_pos && !bus.motor_active;
  assign head_pos = mem[rd_ptr][31:13];
  assign head_div = mem[rd_ptr][12:0];
  assign bus.cmd_ready = !full && !bus.flush && !reset;
  assign bus.level = level;
  assign bus.busy = state != IDLE;
  assign bus.newPos = new_pos;
  assign bus.divider = divider;
  // entry storage; needs no reset since level gates every read
  always_ff @(posedge CLK)
    if (push) mem[wr_ptr] <= {bus.cmd_pos, bus.cmd_div};
  // pointers and occupancy; flush empties the queue outright
  always_ff @(posedge CLK)
    if (reset || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  // sequencer state register
  always_ff @(posedge CLK)
    state <= reset ? IDLE : state_nx;
  // next state: wait for a queued move, load it, run until the position matches and the motor is idle
  always_comb begin
    state_nx = state;
    state_nx = bus.flush ? IDLE :
               state == IDLE ? (level != 0 ? LOAD : IDLE) :
               state == LOAD ? RUN :
               done ? IDLE : RUN;
  end
`ifdef MOTOR_CMD_QUEUE_RAMP_EN
  logic step_d, step_rise, decel, accel;
  logic [12:0] tgt_div, ramp_div;
  logic [18:0] accel_cnt, ramp_cnt, remaining;
  logic [19:0] diff;
  logic [13:0] up, dn;
  // per-step ramp: decelerate once the steps left fit inside the steps spent accelerating
  always_comb begin
    step_rise = bus.step_in && !step_d;
    diff = {new_pos[18], new_pos} - {bus.cur_position[18], bus.cur_position};
    remaining = diff[19] ? 19'(-diff) : diff[18:0];
    up = {1'b0, divider} + {1'b0, RAMP_STEP};
    dn = {1'b0, divider} - {1'b0, RAMP_STEP};
    decel = remaining <= accel_cnt;
    accel = divider > tgt_div;
    ramp_div = decel ? (up > {1'b0, START_DIV} ? START_DIV : up[12:0]) :
               accel ? (dn[13] || dn < {1'b0, tgt_div} ? tgt_div : dn[12:0]) : divider;
    ramp_cnt = decel ? (accel_cnt == '0 ? accel_cnt : accel_cnt - 1'b1) :
               accel ? (&accel_cnt ? accel_cnt : accel_cnt + 1'b1) : accel_cnt;
    load_div = head_div > START_DIV ? head_div : START_DIV;
  end
  // move outputs and ramp state; flush parks the target on the current position
  always_ff @(posedge CLK)
    if (reset) begin
      new_pos <= '0;
      divider <= START_DIV;
      tgt_div <= '0;
      accel_cnt <= '0;
      step_d <= 1'b0;
    end else begin
      step_d <= bus.step_in;
      if (bus.flush) new_pos <= bus.cur_position;
      else if (state == LOAD) begin
        new_pos <= head_pos;
        divider <= load_div;
        tgt_div <= head_div;
        accel_cnt <= '0;
      end else if (state == RUN && step_rise) begin
        divider <= ramp_div;
        accel_cnt <= ramp_cnt;
      end
    end
`else
  assign load_div = head_div;
  // move outputs; divider is fixed for the whole move, flush parks the target on the current position
  always_ff @(posedge CLK)
    if (reset) begin
      new_pos <= '0;
      divider <= START_DIV;
    end else if (bus.flush) new_pos <= bus.cur_position;
    else if (state == LOAD) begin
      new_pos <= head_pos;
      divider <= load_div;
    end
`endif
endmodule

// File: tb/tb_motor_cmd_queue.sv
// tb_motor_cmd_queue: directed checks of queueing, issue timing, flush and divider profile against a simple stepping motor model
module tb_motor_cmd_queue;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  motor_cmd_queue_if #(.DEPTH(4)) q();
  motor_cmd_queue #(.DEPTH(4), .START_DIV(13'd100), .RAMP_STEP(13'd10)) dut (
    .CLK(clk), .reset(rst), .bus(q)
  );
  int checks = 0;
  int errors = 0;
  int cur = 0;
  int cnt = 0;
  int last_np = 0;
  bit motor_en = 1;
  int divs[$];
  int tgts[$];
`ifdef MOTOR_CMD_QUEUE_RAMP_EN
  int exp20[20] = '{100, 90, 80, 70, 60, 50, 50, 50, 50, 50, 50, 50, 50, 50, 50, 60, 70, 80, 90, 100};
  int exp4[4] = '{100, 90, 80, 90};
`else
  int exp20[20] = '{default: 50};
  int exp4[4] = '{default: 50};
`endif
  int exp_fifo[5] = '{34, 30, 35, 31, 36};
  int exp_lvl[5] = '{1, 2, 2, 3, 4};
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int np();
    return int'($signed(q.newPos));
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    q.step_in = 0;
    if (motor_en && cur != np()) begin
      cnt++;
      if (cnt == 3) begin
        cnt = 0;
        q.step_in = 1;
        cur += (np() > cur) ? 1 : -1;
        divs.push_back(int'(q.divider));
      end
    end else cnt = 0;
    q.cur_position = 19'(cur);
    q.motor_active = motor_en && cur != np();
    if (np() != last_np) begin
      last_np = np();
      tgts.push_back(last_np);
    end
  endtask
  task automatic offer(input int pos, input int div);
    q.cmd_valid = 1;
    q.cmd_pos = 19'(pos);
    q.cmd_div = 13'(div);
    tick();
    q.cmd_valid = 0;
  endtask
  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while ((q.busy || q.level != 0) && n < budget);
    check(tag, int'(q.busy || q.level != 0), 0);
  endtask
  initial begin
    q.cmd_valid = 0;
    q.cmd_pos = '0;
    q.cmd_div = '0;
    q.flush = 0;
    q.cur_position = '0;
    q.motor_active = 0;
    q.step_in = 0;
    repeat (3) tick();
    check("rst_ready", q.cmd_ready, 0);
    check("rst_newpos", np(), 0);
    check("rst_div", q.divider, 100);
    check("rst_busy", q.busy, 0);
    check("rst_level", q.level, 0);
    rst = 0;
    #1;
    check("ready_after_rst", q.cmd_ready, 1);
    offer(100, 50);
    check("t1_level", q.level, 1);
    check("t1_busy_k", q.busy, 0);
    tick();
    check("t1_busy_load", q.busy, 1);
    check("t1_np_load", np(), 0);
    tick();
    check("t1_np", np(), 100);
`ifdef MOTOR_CMD_QUEUE_RAMP_EN
    check("t1_div", q.divider, 100);
`else
    check("t1_div", q.divider, 50);
`endif
    wait_idle("t1_done", 2000);
    check("t1_final_np", np(), 100);
    offer(100, 30);
    tick();
    tick();
    check("zero_busy_run", q.busy, 1);
`ifdef MOTOR_CMD_QUEUE_RAMP_EN
    check("zero_div", q.divider, 100);
`else
    check("zero_div", q.divider, 30);
`endif
    tick();
    check("zero_done", q.busy, 0);
    offer(-20, 10);
    tick();
    tick();
    check("neg_np", np(), -20);
    wait_idle("neg_done", 2000);
`ifdef MOTOR_CMD_QUEUE_RAMP_EN
    check("neg_end_div", q.divider, 100);
`else
    check("neg_end_div", q.divider, 10);
`endif
    divs.delete();
    offer(0, 50);
    wait_idle("prof20_done", 2000);
    check("prof20_steps", divs.size(), 20);
    for (int i = 0; i < divs.size() && i < 20; i++) check($sformatf("prof20_%0d", i), divs[i], exp20[i]);
    divs.delete();
    offer(4, 50);
    wait_idle("prof4_done", 500);
    check("prof4_steps", divs.size(), 4);
    for (int i = 0; i < divs.size() && i < 4; i++) check($sformatf("prof4_%0d", i), divs[i], exp4[i]);
    tgts.delete();
    for (int i = 0; i < 5; i++) begin
      offer(exp_fifo[i], 20);
      check($sformatf("fifo_level_%0d", i), q.level, exp_lvl[i]);
    end
    check("fifo_full_ready", q.cmd_ready, 0);
    offer(99, 20);
    check("fifo_full_level", q.level, 4);
    wait_idle("fifo_done", 3000);
    check("fifo_count", tgts.size(), 5);
    for (int i = 0; i < tgts.size() && i < 5; i++) check($sformatf("fifo_order_%0d", i), tgts[i], exp_fifo[i]);
    offer(136, 10);
    offer(0, 10);
    offer(5, 10);
    for (int n = 0; n < 40 && cur != 37; n++) tick();
    check("flush_reach", cur, 37);
    motor_en = 0;
    q.motor_active = 0;
    check("flush_pre_level", q.level, 2);
    q.flush = 1;
    q.cmd_valid = 1;
    q.cmd_pos = 19'd99;
    q.cmd_div = 13'd10;
    #1;
    check("flush_ready", q.cmd_ready, 0);
    tick();
    q.flush = 0;
    q.cmd_valid = 0;
    check("flush_level", q.level, 0);
    check("flush_np", np(), 37);
    check("flush_busy", q.busy, 0);
    motor_en = 1;
    tick();
    tick();
    check("flush_nopush_level", q.level, 0);
    check("flush_idle", q.busy, 0);
    offer(40, 10);
    wait_idle("recover_done", 500);
    check("recover_np", np(), 40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
